// File: rtl/serial_word_rx.sv
// Serial-in, parallel-out word receiver with a one-deep valid/ready output register, sticky overrun flag,
// 1-cycle completion-to-dout latency; a word that completes while dout is held drops. Optional: SERIAL_WORD_RX_PARITY_CHECK_EN.
module serial_word_rx #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         frame_start,
  input  logic         lsb_first,
  output logic [n-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         overrun,
  input  logic         ovr_clr,
  output logic         busy
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
  ,
  output logic         parity_err
`endif
);

`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
  localparam int LAST = n;
`else
  localparam int LAST = n - 1;
`endif
  localparam int CW = $clog2(n + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [n-1:0]   shift_q, shift_d;
  logic           order_q, order_d;
  logic [n-1:0]   dout_q, dout_d;
  logic           dout_valid_q, dout_valid_d;
  logic           overrun_q, overrun_d;
  logic           busy_q, busy_d;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
  logic           parity_err_q, parity_err_d;
`endif

  logic           restart;
  logic           order_cur;
  logic [CW-1:0]  count_cur;
  logic [n-1:0]   shift_cur;
  logic [n-1:0]   shifted;
  logic           complete;
  logic [n-1:0]   word;
  logic           word_perr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      order_q      <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      order_q      <= order_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // frame_start makes the current cycle behave exactly like the first cycle of a fresh word
  assign restart = frame_start || (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = sin_valid ? SHIFT : IDLE;
    end else if (sin_valid && (count_q == CW'(LAST))) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    order_cur = restart ? lsb_first : order_q;
    count_cur = restart ? '0 : count_q;
    shift_cur = restart ? '0 : shift_q;
    shifted   = order_cur ? {sin, shift_cur[n-1:1]} : {shift_cur[n-2:0], sin};
    complete  = sin_valid && (count_cur == CW'(LAST));
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    // the final bit is parity, so the data word is already complete in the shift register
    word      = shift_cur;
    word_perr = ^{shift_cur, sin};
`else
    word      = shifted;
    word_perr = 1'b0;
`endif

    order_d = order_q;
    count_d = count_q;
    shift_d = shift_q;
    if (sin_valid) begin
      order_d = order_cur;
      shift_d = shifted;
      count_d = complete ? '0 : count_cur + CW'(1);
    end else if (frame_start) begin
      count_d = '0;
      shift_d = '0;
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (complete) begin
      if (dout_valid_q && !dout_ready) begin
        overrun_d = 1'b1;
      end else begin
        dout_d       = word;
        dout_valid_d = 1'b1;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
        parity_err_d = word_perr;
`endif
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
    busy_d = (count_d != '0);
  end

`ifndef SERIAL_WORD_RX_PARITY_CHECK_EN
  logic unused_perr;
  assign unused_perr = word_perr;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: directed scenarios then random traffic against a bit-queue reference model.
module tb_serial_word_rx;
  localparam int N = 8;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
  localparam int WB = N + 1;
`else
  localparam int WB = N;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         lsb_first = 1'b0;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overrun;
  logic         ovr_clr = 1'b0;
  logic         busy;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
  logic         parity_err;
  logic         m_perr;
`endif

  int checks = 0;
  int errors = 0;

  int           m_cnt;
  logic         m_order;
  logic         m_bits [WB];
  logic [N-1:0] m_dout;
  logic         m_vld;
  logic         m_ovr;
  logic         m_busy;

  serial_word_rx #(.n(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .frame_start(frame_start),
    .lsb_first  (lsb_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .busy       (busy)
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: collect bits of the current word in arrival order, build the word arithmetically at the end.
  task automatic model_edge();
    logic         comp;
    logic [N-1:0] w;
    comp = 1'b0;
    w = '0;
    if (!reset_n) begin
      m_cnt = 0; m_order = 1'b0; m_dout = '0; m_vld = 1'b0; m_ovr = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
      m_perr = 1'b0;
`endif
    end else begin
      if (frame_start) m_cnt = 0;
      if (sin_valid) begin
        if (m_cnt == 0) m_order = lsb_first;
        m_bits[m_cnt] = sin;
        m_cnt++;
        if (m_cnt == WB) begin
          comp = 1'b1;
          m_cnt = 0;
        end
      end
      if (comp) begin
        for (int i = 0; i < N; i++)
          if (m_bits[i]) w = w | N'(m_order ? (1 << i) : (1 << (N - 1 - i)));
      end
      if (ovr_clr) m_ovr = 1'b0;
      if (comp) begin
        if (m_vld && !dout_ready) m_ovr = 1'b1;
        else begin
          m_dout = w;
          m_vld = 1'b1;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
          m_perr = 1'b0;
          for (int i = 0; i < WB; i++) m_perr = m_perr ^ m_bits[i];
`endif
        end
      end else if (m_vld && dout_ready) m_vld = 1'b0;
    end
    m_busy = (m_cnt != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_vld));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("busy", 32'(busy), 32'(m_busy));
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic send_bit(input logic b, input logic lsb);
    sin = b;
    sin_valid = 1'b1;
    lsb_first = lsb;
    tick();
    sin_valid = 1'b0;
  endtask

  // seq[N-1] goes on the wire first; an even-parity bit is appended when parity is enabled
  task automatic send_word(input logic [N-1:0] seq, input logic lsb);
    for (int i = 0; i < N; i++) send_bit(seq[N-1-i], lsb);
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    send_bit(^seq, lsb);
`endif
  endtask

  initial begin
    m_cnt = 0; m_order = 1'b0; m_dout = '0; m_vld = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    m_perr = 1'b0;
`endif
    @(negedge clk);
    tick();
    tick();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    dout_ready = 1'b1;

    send_word(8'hA5, 1'b0);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_valid", 32'(dout_valid), 32'h1);
    tick();
    chk("a5_valid_drop", 32'(dout_valid), 32'h0);

    send_word(8'h80, 1'b0);
    chk("msb_first", 32'(dout), 32'h80);
    send_word(8'h80, 1'b1);
    chk("lsb_first", 32'(dout), 32'h01);
    for (int i = 0; i < N; i++) send_bit(i == 0, i >= 3);
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    send_bit(1'b1, 1'b1);
`endif
    chk("order_held", 32'(dout), 32'h80);
    tick();

    dout_ready = 1'b0;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    chk("ovr_dout", 32'(dout), 32'h11);
    chk("ovr_set", 32'(overrun), 32'h1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'h0);
    dout_ready = 1'b1;
    tick();
    chk("drain_valid", 32'(dout_valid), 32'h0);

    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    frame_start = 1'b1;
    send_bit(1'b1, 1'b0);
    frame_start = 1'b0;
    chk("fs_busy", 32'(busy), 32'h1);
    for (int i = 0; i < N - 1; i++) send_bit(1'b0, 1'b0);
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    send_bit(1'b1, 1'b0);
`endif
    chk("fs_dout", 32'(dout), 32'h80);
    chk("fs_busy_done", 32'(busy), 32'h0);

    dout_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    tick();
    chk("mrst_dout", 32'(dout), 32'h0);
    chk("mrst_valid", 32'(dout_valid), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    dout_ready = 1'b1;
    send_word(8'hFF, 1'b0);
    chk("post_rst_ff", 32'(dout), 32'hFF);

`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    for (int i = 0; i < N; i++) send_bit(i >= N - 3, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("par_ok", 32'(parity_err), 32'h0);
    for (int i = 0; i < N; i++) send_bit(i >= N - 3, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("par_bad", 32'(parity_err), 32'h1);
    chk("par_dout", 32'(dout), 32'h07);
`endif

    for (int c = 0; c < 1500; c++) begin
      reset_n     = ($urandom_range(0, 59) != 0);
      sin         = 1'($urandom);
      sin_valid   = ($urandom_range(0, 9) < 7);
      frame_start = ($urandom_range(0, 29) == 0);
      lsb_first   = 1'($urandom);
      dout_ready  = ($urandom_range(0, 2) == 0);
      ovr_clr     = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
Serial-in, parallel-out word receiver. It is the receiving end of the serial link driven by the team's parallel-load shift registers. It accepts one bit per qualified clock, assembles n-bit words MSB-first or LSB-first, and presents each finished word on a one-deep output register with a valid/ready handshake. Overrun is detected and flagged. Sits between a serial line front-end and any parallel consumer.

Parameters:
n, 8, word width in bits (n >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising clk
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled this cycle when 1
frame_start  input  1  resync: discard any partial word
lsb_first  input  1  bit order of the word that starts this cycle (0 = MSB-first, 1 = LSB-first)
dout  output  n  assembled word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout this cycle
overrun  output  1  sticky: a completed word was dropped
ovr_clr  input  1  clears overrun
busy  output  1  partial word in progress (bit count != 0)

Behaviour:
- Reset (reset_n=0 at a rising edge): shift reg=0, bit count=0, dout=0, dout_valid=0, overrun=0, busy=0, latched order=0. Reset has priority over every other input.
- State machine IDLE/SHIFT:
  - IDLE (count=0): sin_valid=1 samples the first bit, latches lsb_first into the order register, count=1, go to SHIFT.
  - SHIFT: each sin_valid=1 samples one bit and increments count.
  - Order is held for the whole word. Changes to lsb_first in mid-word are ignored.
- Bit placement:
  - MSB-first: shift left, new bit enters bit 0.
  - LSB-first: shift right, new bit enters bit n-1.
  - After n bits the first-sampled bit is bit n-1 (MSB-first) or bit 0 (LSB-first).
- Completion: on the edge where sin_valid=1 and count=n-1, the full word including that bit is offered to the output register, count returns to 0 and the FSM returns to IDLE.
  - dout/dout_valid are visible 1 cycle after the last bit is sampled.
  - Back-to-back words with no idle cycle are supported.
- Output register:
  - dout_valid&dout_ready at an edge with no completion: dout_valid goes to 0. dout keeps its value.
  - Completion with dout_valid=0, or with dout_valid&dout_ready=1 at the same edge: load dout, dout_valid=1, no overrun.
  - Completion with dout_valid=1 and dout_ready=0: the new word is dropped, dout is unchanged, overrun is set to 1.
- overrun:
  - Set per the rule above. Cleared by ovr_clr=1.
  - If set and clear occur at the same edge, set wins.
- frame_start=1: partial word discarded, count=0.
  - If sin_valid=1 in the same cycle, that bit is the first bit of a new word, and lsb_first is latched for that word.
  - frame_start never affects dout, dout_valid or overrun.
- sin_valid=0: no state change in the shift path. Bubbles between bits are allowed.
- busy = (count != 0), registered.
- Count width is clog2(n+1). No wrap beyond n-1 is possible.

Optional Feature:
Macro: SERIAL_WORD_RX_PARITY_CHECK_EN.
- When defined:
  - Each word is n data bits followed by one even-parity bit, covering the data bits plus the parity bit. The parity bit is not stored in dout.
  - Completion occurs on the parity bit, so the data-bit completion rule moves to count=n.
  - Adds output parity_err (1 bit), loaded together with dout: 1 when the XOR of the n data bits and the parity bit is 1.
  - parity_err is reset to 0. Drop/overrun rules apply unchanged, and a dropped word does not update parity_err.
- When undefined: no parity_err port. Words are exactly n bits.

Test Plan:
- n=8, lsb_first=0, bits 1,0,1,0,0,1,0,1 on consecutive cycles, dout_ready=1 -> dout=0xA5, dout_valid=1 for exactly 1 cycle, starting 1 cycle after the 8th bit.
- Bit order: sequence 1,0,0,0,0,0,0,0 with lsb_first=0 -> dout=0x80. Same sequence with lsb_first=1 -> dout=0x01. Toggling lsb_first after bit 3 does not change the result.
- dout_ready=0, send 0x11 then 0x22 -> dout stays 0x11, overrun=1. Pulse ovr_clr -> overrun=0. Then dout_ready=1 -> dout_valid drops.
- Send 3 bits, then frame_start=1 with sin_valid=1, sin=1, followed by 7 zeros (MSB-first) -> dout=0x80. busy=1 from the bit after the frame_start cycle until completion.
- reset_n=0 for one clk in mid-word and with dout_valid=1 -> all outputs 0. The next 8 bits 0xFF give dout=0xFF.
- PARITY_CHECK_EN: 0x07 followed by parity 1 -> parity_err=0. 0x07 followed by parity 0 -> parity_err=1.
